mux_2to1_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 2:1 mux datapath between two valid/ready requesters.

---
 rtl/mux_2to1_arbiter_pkg.sv | 7 +
 rtl/mux_2to1.sv | 11 +
 rtl/mux_2to1_arbiter.sv | 82 ++++++++
 tb/tb_mux_2to1_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mux_2to1_arbiter_pkg.sv
// mux_2to1_arbiter_pkg: arbiter state encodings and counter-width helper shared with future N-way arbiters
package mux_2to1_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;
  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction
endpackage

// File: rtl/mux_2to1.sv
// mux_2to1: width-parameterised 2:1 payload select
module mux_2to1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic             sel,
  output logic [WIDTH-1:0] dout
);
  assign dout = sel ? din1 : din0;
endmodule

// File: rtl/mux_2to1_arbiter.sv
// mux_2to1_arbiter: round-robin, burst-bounded arbiter sharing one 2:1 mux with a registered output stage
module mux_2to1_arbiter
  import mux_2to1_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din0_valid,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic                  din0_ready,
  input  logic                  din1_valid,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  din1_ready,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  dout_ready,
  output logic                  sel,
  output logic                  busy
);
  localparam int CW = cnt_w(MAX_BURST);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
  state_t state, state_nx;
  logic [CW-1:0] beat_cnt, cnt_nx, cnt_acc;
  logic last_served, ls_nx;
  logic out_free, acc, cur_valid, oth_valid;
  logic [DATA_WIDTH-1:0] mux_out;
  mux_2to1 #(.WIDTH(DATA_WIDTH)) u_mux (
    .din0(din0),
    .din1(din1),
    .sel (sel),
    .dout(mux_out)
  );
  assign out_free   = !dout_valid || dout_ready;
  assign din0_ready = (state == GRANT0) && out_free;
  assign din1_ready = (state == GRANT1) && out_free;
  assign acc        = (din0_valid && din0_ready) || (din1_valid && din1_ready);
  assign cur_valid  = (state == GRANT1) ? din1_valid : din0_valid;
  assign oth_valid  = (state == GRANT1) ? din0_valid : din1_valid;
  assign cnt_acc    = !acc ? beat_cnt : (beat_cnt == MAXC) ? MAXC : beat_cnt + CW'(1);
  always_comb begin
    state_nx = state;
    cnt_nx   = beat_cnt;
    ls_nx    = last_served;
    if (state == IDLE) begin
      state_nx = (din0_valid && (!din1_valid || last_served)) ? GRANT0 : din1_valid ? GRANT1 : IDLE;
    end else begin
      cnt_nx = cnt_acc;
      if (!cur_valid || (oth_valid && cnt_acc == MAXC))
        state_nx = !oth_valid ? IDLE : (state == GRANT0) ? GRANT1 : GRANT0;
      // leaving a grant restarts the burst count and records who was served
      if (state_nx != state) begin
        cnt_nx = '0;
        ls_nx  = (state == GRANT1);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      last_served <= 1'b1;
      sel         <= 1'b0;
      busy        <= 1'b0;
      dout_valid  <= 1'b0;
      dout        <= '0;
    end else begin
      state       <= state_nx;
      beat_cnt    <= cnt_nx;
      last_served <= ls_nx;
      sel         <= (state_nx == GRANT1);
      busy        <= (state_nx != IDLE);
      if (acc) begin
        dout       <= mux_out;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_2to1_arbiter.sv
// tb_mux_2to1_arbiter: directed scenarios plus randomized traffic against a behavioural model and scoreboard
module tb_mux_2to1_arbiter;
  localparam int DW = 8;
  localparam int MAXB = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic din0_valid = 1'b0, din1_valid = 1'b0, dout_ready = 1'b0;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic din0_ready, din1_ready, dout_valid, sel, busy;
  logic [DW-1:0] dout;
  int checks = 0, failures = 0;
  int m_own, m_cnt, m_last;
  logic m_dv;
  logic [DW-1:0] m_dout;
  logic s_r0, s_r1, e_r0, e_r1;
  mux_2to1_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .din0_valid(din0_valid), .din0(din0), .din0_ready(din0_ready),
    .din1_valid(din1_valid), .din1(din1), .din1_ready(din1_ready),
    .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
    .sel(sel), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    m_own = 0; m_cnt = 0; m_last = 1; m_dv = 1'b0; m_dout = '0;
  endtask
  // model owner: 0 = nobody, 1 = requester 0, 2 = requester 1
  task automatic tick(input logic v0, input logic [DW-1:0] d0, input logic v1, input logic [DW-1:0] d1, input logic dr);
    int me, nown, c;
    logic a0, a1, mv, ov;
    din0_valid = v0; din0 = d0; din1_valid = v1; din1 = d1; dout_ready = dr;
    #1;
    s_r0 = din0_ready; s_r1 = din1_ready;
    e_r0 = (m_own == 1) && (!m_dv || dr);
    e_r1 = (m_own == 2) && (!m_dv || dr);
    a0 = v0 && e_r0; a1 = v1 && e_r1;
    if (a0 || a1) begin m_dout = a0 ? d0 : d1; m_dv = 1'b1; end
    else if (dr) m_dv = 1'b0;
    if (m_own == 0) begin
      nown = (v0 && (!v1 || m_last == 1)) ? 1 : v1 ? 2 : 0;
    end else begin
      me = m_own - 1;
      mv = me ? v1 : v0; ov = me ? v0 : v1;
      c = (a0 || a1) ? ((m_cnt + 1 < MAXB) ? m_cnt + 1 : MAXB) : m_cnt;
      nown = !mv ? (ov ? 2 - me : 0) : (ov && c == MAXB) ? 2 - me : m_own;
      if (nown != m_own) begin m_cnt = 0; m_last = me; end else m_cnt = c;
    end
    m_own = nown;
    @(posedge clk); @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1; din0_valid = 0; din1_valid = 0; dout_ready = 0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; model_reset();
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if ({dout_valid, dout, sel, busy, din0_ready, din1_ready} !== '0) begin failures++; $display("FAIL reset_state got dv=%b dout=%h sel=%b busy=%b r0=%b r1=%b want all 0", dout_valid, dout, sel, busy, din0_ready, din1_ready); end
  endtask
  task automatic test_single_stream();
    logic [DW-1:0] exp [3];
    exp[0] = 8'hA1; exp[1] = 8'hA2; exp[2] = 8'hA3;
    do_reset();
    tick(1, exp[0], 0, 0, 1);
    checks++; if (s_r0 !== 1'b0) begin failures++; $display("FAIL idle_no_ready got %b want 0", s_r0); end
    checks++; if (busy !== 1'b1 || sel !== 1'b0 || dout_valid !== 1'b0) begin failures++; $display("FAIL grant_t1 got busy=%b sel=%b dv=%b want 1 0 0", busy, sel, dout_valid); end
    for (int i = 0; i < 3; i++) begin
      tick(1, exp[i], 0, 0, 1);
      checks++; if (s_r0 !== 1'b1 || dout_valid !== 1'b1 || dout !== exp[i] || sel !== 1'b0) begin failures++; $display("FAIL stream_beat%0d got r0=%b dv=%b dout=%h sel=%b want 1 1 %h 0", i, s_r0, dout_valid, dout, sel, exp[i]); end
    end
    tick(0, 0, 0, 0, 1);
    checks++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stream_drain got dv=%b busy=%b want 0 0", dout_valid, busy); end
  endtask
  task automatic test_round_robin();
    int k, n0, n1, side;
    logic [DW-1:0] want;
    do_reset();
    k = 0; n0 = 0; n1 = 0;
    for (int t = 0; t < 22; t++) begin
      tick(1, DW'(8'h10 + n0), 1, DW'(8'h80 + n1), 1);
      if (s_r0 || s_r1) begin
        side = (k / MAXB) % 2;
        want = side ? DW'(8'h80 + n1) : DW'(8'h10 + n0);
        checks++; if (s_r1 !== side[0] || s_r0 === s_r1 || dout !== want || sel !== ((((k + 1) / MAXB) % 2) == 1)) begin failures++; $display("FAIL rr_beat%0d got r0=%b r1=%b dout=%h sel=%b want side=%0d dout=%h", k, s_r0, s_r1, dout, sel, side, want); end
        if (s_r0) n0++; else n1++;
        k++;
      end
    end
    checks++; if (k !== 21 || n0 !== 12 || n1 !== 9) begin failures++; $display("FAIL rr_count got k=%0d n0=%0d n1=%0d want 21 12 9", k, n0, n1); end
  endtask
  task automatic test_backpressure();
    do_reset();
    tick(1, 8'h5C, 0, 0, 1);
    tick(1, 8'h5C, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1, 8'h77, 1, 8'h66, 0);
      checks++; if (s_r0 !== 1'b0 || s_r1 !== 1'b0 || dout_valid !== 1'b1 || dout !== 8'h5C || dut.beat_cnt !== 1) begin failures++; $display("FAIL bp_hold%0d got r0=%b r1=%b dv=%b dout=%h cnt=%0d want 0 0 1 5c 1", i, s_r0, s_r1, dout_valid, dout, dut.beat_cnt); end
    end
    tick(1, 8'h77, 1, 8'h66, 1);
    checks++; if (s_r0 !== 1'b1 || dout !== 8'h77 || dout_valid !== 1'b1) begin failures++; $display("FAIL bp_release got r0=%b dout=%h dv=%b want 1 77 1", s_r0, dout, dout_valid); end
  endtask
  task automatic test_drop_switch();
    do_reset();
    tick(1, 8'h01, 1, 8'h91, 1);
    tick(1, 8'h01, 1, 8'h91, 1);
    tick(1, 8'h02, 1, 8'h91, 1);
    tick(0, 8'h03, 1, 8'h91, 1);
    checks++; if (sel !== 1'b1 || busy !== 1'b1 || dut.beat_cnt !== 0 || dut.last_served !== 1'b0) begin failures++; $display("FAIL drop_switch got sel=%b busy=%b cnt=%0d last=%b want 1 1 0 0", sel, busy, dut.beat_cnt, dut.last_served); end
    tick(0, 8'h03, 1, 8'h91, 1);
    checks++; if (s_r1 !== 1'b1 || dout !== 8'h91) begin failures++; $display("FAIL drop_accept got r1=%b dout=%h want 1 91", s_r1, dout); end
  endtask
  task automatic test_reset_mid_burst();
    do_reset();
    tick(0, 0, 1, 8'hB1, 1);
    tick(0, 0, 1, 8'hB1, 1);
    tick(1, 8'h0F, 1, 8'hB2, 1);
    din0_valid = 1; din1_valid = 1;
    #2 rst = 1'b1;
    #1;
    checks++; if ({dout_valid, dout, sel, busy, din0_ready, din1_ready} !== '0) begin failures++; $display("FAIL async_reset got dv=%b dout=%h sel=%b busy=%b r0=%b r1=%b want all 0", dout_valid, dout, sel, busy, din0_ready, din1_ready); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0; model_reset();
    tick(1, 8'h0A, 1, 8'hBA, 1);
    checks++; if (s_r0 !== 1'b0 || s_r1 !== 1'b0 || busy !== 1'b1 || sel !== 1'b0) begin failures++; $display("FAIL post_reset_idle got r0=%b r1=%b busy=%b sel=%b want 0 0 1 0", s_r0, s_r1, busy, sel); end
    tick(1, 8'h0A, 1, 8'hBA, 1);
    checks++; if (s_r0 !== 1'b1 || dout !== 8'h0A) begin failures++; $display("FAIL post_reset_tie got r0=%b dout=%h want 1 0a", s_r0, dout); end
  endtask
  task automatic test_random();
    logic [DW-1:0] q [$];
    logic [DW-1:0] d0, d1, pre_d, exp;
    logic v0, v1, dr, pre_dv;
    do_reset();
    for (int t = 0; t < 400; t++) begin
      v0 = ($urandom_range(0, 3) != 0); v1 = ($urandom_range(0, 2) != 0);
      d0 = DW'($urandom); d1 = DW'($urandom); dr = ($urandom_range(0, 3) != 0);
      pre_dv = dout_valid; pre_d = dout;
      tick(v0, d0, v1, d1, dr);
      checks++; if (s_r0 !== e_r0 || s_r1 !== e_r1) begin failures++; $display("FAIL rand_ready t=%0d got %b%b want %b%b", t, s_r0, s_r1, e_r0, e_r1); end
      checks++; if (dout_valid !== m_dv || (m_dv && dout !== m_dout) || sel !== (m_own == 2) || busy !== (m_own != 0)) begin failures++; $display("FAIL rand_state t=%0d got dv=%b dout=%h sel=%b busy=%b want dv=%b dout=%h own=%0d", t, dout_valid, dout, sel, busy, m_dv, m_dout, m_own); end
      if (pre_dv && dr) begin
        exp = (q.size() > 0) ? q.pop_front() : ~pre_d;
        checks++; if (pre_d !== exp) begin failures++; $display("FAIL rand_order t=%0d got %h want %h", t, pre_d, exp); end
      end
      if (v0 && s_r0) q.push_back(d0);
      if (v1 && s_r1) q.push_back(d1);
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_single_stream();
    test_round_robin();
    test_backpressure();
    test_drop_switch();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
